// File: rtl/stack_spill_ctrl.sv
// stack_spill_ctrl: tracks on-chip stack buffer occupancy and sequences
// burst spills to / fills from data memory, stalling the core meanwhile.
module stack_spill_ctrl #(
  parameter int              DEPTH      = 16,
  parameter int              BURST      = 4,
  parameter int              AW         = 16,
  parameter logic [AW-1:0]   SPILL_BASE = 16'hF000,
  parameter int              MEM_MAX    = 1024,
  localparam int             OW         = $clog2(DEPTH + 1),
  localparam int             SW         = $clog2(MEM_MAX + 1)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  output logic          stall,
  output logic          spill_rd,
  output logic          fill_wr,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  output logic [OW-1:0] occ,
  output logic [SW-1:0] spilled,
  output logic          ovf,
  output logic          unf
);

  localparam int             CW        = $clog2(BURST + 1);
  localparam logic [OW-1:0]  OCC_FULL  = OW'(DEPTH);
  localparam logic [CW-1:0]  CNT_BURST = CW'(BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPILL = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [SW-1:0] spilled_q, spilled_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          net_push;
  logic          net_pop;
  logic          spill_fits;
  logic [CW-1:0] fill_len;
  logic          stall_c;
  logic          spill_rd_c;
  logic          fill_wr_c;

  // Replace-top on an empty buffer is a pop-then-push, i.e. a net push.
  assign net_push   = push & (~pop | (occ_q == '0));
  assign net_pop    = pop & ~push;
  assign spill_fits = (32'(spilled_q) + 32'(BURST)) <= 32'(MEM_MAX);
  assign fill_len   = (32'(spilled_q) < 32'(BURST)) ? CW'(spilled_q) : CNT_BURST;

  // Memory request is decoded purely from registered state so it is stable until ack.
  assign mem_req  = (state_q != IDLE);
  assign mem_we   = (state_q == SPILL);
  assign mem_addr = (state_q == SPILL) ? SPILL_BASE + AW'(spilled_q) :
                    (state_q == FILL)  ? SPILL_BASE + AW'(spilled_q) - AW'(1) :
                                         '0;

  assign stall    = stall_c;
  assign spill_rd = spill_rd_c;
  assign fill_wr  = fill_wr_c;
  assign occ      = occ_q;
  assign spilled  = spilled_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

  // Next-state, occupancy bookkeeping and the combinational stall/pulse outputs.
  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    spilled_d  = spilled_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    stall_c    = 1'b0;
    spill_rd_c = 1'b0;
    fill_wr_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (net_push) begin
          if (occ_q != OCC_FULL) begin
            occ_d = occ_q + OW'(1);
          end else if (spill_fits) begin
            stall_c = 1'b1;
            cnt_d   = CNT_BURST;
            state_d = SPILL;
          end else begin
            ovf_d = 1'b1;  // push is dropped
          end
        end else if (net_pop) begin
          if (occ_q != '0) begin
            occ_d = occ_q - OW'(1);
          end else if (spilled_q != '0) begin
            stall_c = 1'b1;
            cnt_d   = fill_len;
            state_d = FILL;
          end else begin
            unf_d = 1'b1;  // pop is dropped
          end
        end
      end

      SPILL: begin
        stall_c = 1'b1;
        if (mem_ack) begin
          spill_rd_c = 1'b1;
          spilled_d  = spilled_q + SW'(1);
          occ_d      = occ_q - OW'(1);
          cnt_d      = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
      end

      FILL: begin
        stall_c = 1'b1;
        if (mem_ack) begin
          fill_wr_c = 1'b1;
          spilled_d = spilled_q - SW'(1);
          occ_d     = occ_q + OW'(1);
          cnt_d     = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // While reset is asserted nothing is handshaken with the core or the buffer.
    if (!reset) begin
      stall_c    = 1'b0;
      spill_rd_c = 1'b0;
      fill_wr_c  = 1'b0;
    end
  end

  // State registers with synchronous active-low reset; reset aborts any burst.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q   <= IDLE;
      occ_q     <= '0;
      spilled_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      occ_q     <= occ_d;
      spilled_q <= spilled_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

endmodule

// File: tb/tb_stack_spill_ctrl.sv
// tb_stack_spill_ctrl: directed plus randomized requests against a
// transaction-level stack occupancy model with a random-latency memory.
module tb_stack_spill_ctrl;

  localparam int          DEPTH   = 4;
  localparam int          BURST   = 2;
  localparam int          AW      = 16;
  localparam int          MEM_MAX = 2;
  localparam logic [15:0] BASE    = 16'hF000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        mem_ack = 1'b0;
  logic        stall, spill_rd, fill_wr, mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [2:0]  occ;
  logic [1:0]  spilled;
  logic        ovf, unf;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_occ, m_spilled;
  bit m_ovf, m_unf;

  always #5 clk = ~clk;

  stack_spill_ctrl #(
    .DEPTH(DEPTH), .BURST(BURST), .AW(AW), .SPILL_BASE(BASE), .MEM_MAX(MEM_MAX)
  ) dut (
    .CLK(clk), .reset(reset), .push(push), .pop(pop), .stall(stall),
    .spill_rd(spill_rd), .fill_wr(fill_wr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .occ(occ), .spilled(spilled),
    .ovf(ovf), .unf(unf)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_occ = 0; m_spilled = 0; m_ovf = 0; m_unf = 0;
  endtask

  // Starts and ends right after a falling edge.
  task automatic apply_reset();
    reset = 1'b0; push = 1'b0; pop = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    #1;
    check_val("rst_ctl", {stall, spill_rd, fill_wr, mem_req, mem_we}, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_cnt", {occ, spilled, ovf, unf}, 0);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  // Issue one core request, hold it through any stall, serve memory with
  // wait states (fixed_wait<0 picks 0..2 per beat), then compare with the model.
  task automatic do_op(input bit p, input bit q, input int fixed_wait);
    bit          net_push, net_pop, exp_we, done, ack;
    int          beats, waitsum, stall_cnt, beat, wcnt, wtarget, exp_stall;
    logic [15:0] addrs[$];

    net_push = p && (!q || m_occ == 0);
    net_pop  = q && !p;
    beats = 0; exp_we = 0; addrs.delete();
    if (net_push) begin
      if (m_occ < DEPTH) m_occ++;
      else if (m_spilled + BURST <= MEM_MAX) begin
        exp_we = 1; beats = BURST;
        for (int i = 0; i < BURST; i++) addrs.push_back(BASE + 16'(m_spilled + i));
        m_spilled += BURST;
        m_occ = m_occ - BURST + 1;
      end else m_ovf = 1;
    end else if (net_pop) begin
      if (m_occ > 0) m_occ--;
      else if (m_spilled > 0) begin
        beats = (m_spilled < BURST) ? m_spilled : BURST;
        for (int i = 0; i < beats; i++) addrs.push_back(BASE + 16'(m_spilled - 1 - i));
        m_spilled -= beats;
        m_occ = beats - 1;
      end else m_unf = 1;
    end

    push = p; pop = q;
    stall_cnt = 0; beat = 0; wcnt = 0; waitsum = 0; wtarget = 0; done = 0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      #1;
      ack = 0;
      if (mem_req) begin
        if (wcnt == 0) begin
          wtarget = (fixed_wait < 0) ? int'($urandom_range(0, 2)) : fixed_wait;
          waitsum += wtarget;
        end
        ack = (wcnt == wtarget);
      end else begin
        check_val("idle_bus", {15'd0, mem_we, mem_addr}, 0);
      end
      mem_ack = ack;
      #1;
      if (stall) stall_cnt++;
      if (ack) begin
        check_val("pulse", {spill_rd, fill_wr}, exp_we ? 2'b10 : 2'b01);
        check_val("we", mem_we, exp_we);
        check_val("addr", mem_addr, (beat < addrs.size()) ? {16'd0, addrs[beat]} : 32'h1_0000);
        beat++; wcnt = 0;
      end else begin
        check_val("nopulse", {spill_rd, fill_wr}, 0);
        if (mem_req) wcnt++;
      end
      done = !stall;
      @(posedge clk);
      #1 mem_ack = 1'b0;
      @(negedge clk);
    end
    push = 1'b0; pop = 1'b0;
    if (!done) check_val("timeout", 0, 1);
    exp_stall = (beats > 0) ? 1 + beats + waitsum : 0;
    check_val("stall_cyc", stall_cnt, exp_stall);
    check_val("beats", beat, beats);
    check_val("occ", occ, m_occ);
    check_val("spilled", spilled, m_spilled);
    check_val("ovf", ovf, m_ovf);
    check_val("unf", unf, m_unf);
    $display("op push=%0b pop=%0b stall=%0d beats=%0d occ=%0d spilled=%0d ovf=%0b unf=%0b",
             p, q, stall_cnt, beat, occ, spilled, ovf, unf);
  endtask

  initial begin
    model_reset();
    apply_reset();

    // plain occupancy, no memory traffic
    repeat (4) do_op(1, 0, 0);
    repeat (4) do_op(0, 1, 0);

    // zero-wait spill, then fill with two wait states per beat
    repeat (4) do_op(1, 0, 0);
    do_op(1, 0, 0);
    repeat (3) do_op(0, 1, 0);
    do_op(0, 1, 2);

    // underflow
    do_op(0, 1, 0);
    do_op(0, 1, 0);

    // replace-top on empty then full buffer
    do_op(1, 1, 0);
    repeat (3) do_op(1, 0, 0);
    do_op(1, 1, 0);

    // fill memory to MEM_MAX, then overflow
    do_op(1, 0, 0);
    do_op(1, 0, 0);
    do_op(1, 0, 0);

    // reset during the first spill beat, then a late ack
    apply_reset();
    repeat (4) do_op(1, 0, 0);
    push = 1'b1;
    #1 check_val("mid_stall", stall, 1);
    @(negedge clk);
    #1;
    check_val("mid_req", mem_req, 1);
    check_val("mid_addr", mem_addr, BASE);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_val("mid_req_drop", mem_req, 0);
    check_val("mid_occ", occ, 0);
    check_val("mid_spilled", spilled, 0);
    @(negedge clk);
    reset = 1'b1; push = 1'b0; mem_ack = 1'b1;
    #1;
    check_val("late_ack", {spill_rd, fill_wr, mem_req, stall}, 0);
    @(posedge clk);
    #1 mem_ack = 1'b0;
    check_val("late_occ", {occ, spilled}, 0);
    @(negedge clk);
    model_reset();

    // randomized traffic with random memory latency
    for (int k = 0; k < 300; k++) begin
      int r;
      if (k % 60 == 59) apply_reset();
      r = int'($urandom_range(0, 9));
      if (r < 5) do_op(1, 0, -1);
      else if (r < 9) do_op(0, 1, -1);
      else do_op(1, 1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
